data_memory_loader: RTL and testbench
=====================================

Name: data_memory_loader

Overview:
- Writer for the data RAM's write port, which the computer top level currently ties off (write data 0, write enables 0).
- Accepts a byte stream with a valid/ready handshake, assembles the bytes little-endian into 32-bit words, and writes them to consecutive RAM word addresses.
- Drives processor_hold while loading, so the top level can gate the processor reset and the processor does not run during a load.
- Sits beside the processor in the computer top level and feeds the RAM's processor-side write port.

Parameters:
- ADDRESS_WIDTH, 10, byte-address width of the RAM port (1 KB).
- COUNT_WIDTH, 9, width of word_count (up to 256 words).

Ports:
- clock  input  1  system clock; the RAM samples on ~clock, mid-cycle.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless state is IDLE or DONE.
- base_address  input  ADDRESS_WIDTH  first byte address; bits [1:0] are ignored (forced to 0).
- word_count  input  COUNT_WIDTH  number of words to write; sampled together with start.
- abort  input  1  ends the load early.
- byte_data  input  8  incoming byte.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_ready  output  1  loader accepts the byte this cycle.
- mem_write_address  output  ADDRESS_WIDTH  RAM byte address, always word aligned.
- mem_write_data  output  32  assembled word.
- mem_write_enable  output  1  one-cycle write strobe.
- processor_hold  output  1  high while loading.
- done  output  1  sticky; high after a load finishes, until the next start or reset.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - All outputs 0: mem_write_address, mem_write_data, mem_write_enable, byte_ready, processor_hold, done.
  - Byte counter and word counter cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE/DONE + start:
  - Latch address={base_address[9:2],2'b00} and remaining=word_count.
  - Clear done.
  - If word_count==0, go to DONE; done rises next cycle; processor_hold is never asserted.
  - Otherwise go to COLLECT with processor_hold=1.
- COLLECT:
  - byte_ready=1.
  - A byte transfers when byte_valid&&byte_ready. Byte k (k=0..3) goes to word bits [8k+7:8k].
  - The transfer of the 4th byte goes to WRITE on the next edge.
  - byte_valid low means no transfer and no state change; there is no timeout.
- WRITE (exactly 1 cycle):
  - mem_write_enable=1, byte_ready=0.
  - mem_write_address and mem_write_data are registered and stable for the whole cycle.
  - Next edge: address+=4, modulo 2^ADDRESS_WIDTH (0x3FC wraps to 0x000); remaining-=1.
  - If remaining becomes 0, go to DONE; otherwise go to COLLECT with the byte counter cleared.
- DONE: processor_hold=0, done=1, byte_ready=0.
- Throughput: 5 cycles per word minimum (4 byte transfers + 1 write cycle).
- abort in COLLECT or WRITE:
  - A WRITE cycle already in progress completes its write.
  - Next state is DONE; a partially assembled word is discarded and never written.
  - abort in IDLE or DONE has no effect.
- Simultaneous start and abort: abort wins in COLLECT/WRITE; start wins in IDLE/DONE.
- start while in COLLECT or WRITE is ignored.
- reset mid-load: immediate return to IDLE next edge. RAM contents already written are kept, the partial word is lost, and processor_hold drops.
- mem_write_address and mem_write_data hold their last values outside WRITE; only mem_write_enable qualifies a write.
- Top-level integration: the processor reset input is reset|processor_hold.

Decomposition:
- Shared package computer_pkg:
  - state enum {IDLE, COLLECT, WRITE, DONE};
  - constants: RAM_ADDRESS_WIDTH=10, WORD_BYTES=4.
- One sub-module, byte_word_packer: 2-bit byte counter plus a 32-bit shift/insert register, with clear and word_full outputs. The FSM and address/count logic stay in the top.

Test Plan:
- Basic load:
  - Stimulus: start, base 0x010, count 2; bytes 11 22 33 44 55 66 77 88 sent back-to-back.
  - Required: write 0x44332211 @0x010, then 0x88776655 @0x014.
  - Exactly 2 write-enable pulses; done rises 1 cycle after the second WRITE; processor_hold is high from the cycle after start until DONE.
- Misaligned base with wrap:
  - Stimulus: base 0x3FE, count 2.
  - Required: writes @0x3FC, then @0x000.
- Gapped valid plus zero count:
  - Stimulus: byte_valid toggled every other cycle with count 1.
  - Required: the same single word is written; byte_ready is 0 during WRITE.
  - Stimulus: count 0.
  - Required: done next cycle, no writes, processor_hold never high.
- Abort:
  - Stimulus: abort after 6 bytes of count 3.
  - Required: exactly 1 write (the first word); done=1; the 2 partial bytes are not written.
  - Stimulus: abort in the same cycle as WRITE.
  - Required: that write still occurs.
- Reset and start interactions:
  - Stimulus: reset asserted mid-COLLECT.
  - Required: all outputs 0 next edge.
  - Stimulus: start pulsed during COLLECT.
  - Required: address and count unchanged.
  - Stimulus: new start from DONE.
  - Required: done clears and the load restarts correctly.

Source files
------------

// File: rtl/computer_pkg.sv
// computer_pkg: shared loader state encoding and RAM geometry constants.
package computer_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  localparam int RAM_ADDRESS_WIDTH = 10;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles four pushed bytes little-endian into a 32-bit word.
module byte_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);
  logic [1:0]  r_count;
  logic [31:0] r_word;
  // o_word already contains the byte being pushed so a full word can be latched on the same edge
  always_comb begin
    o_word = r_word;
    o_word[{r_count, 3'b000} +: 8] = i_byte;
  end
  assign o_word_full = i_push && r_count == 2'd3;
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_count <= '0;
      r_word  <= '0;
    end else if (i_push) begin
      r_count <= r_count + 2'd1;
      r_word  <= o_word;
    end
  end
endmodule

// File: rtl/data_memory_loader.sv
// data_memory_loader: streams bytes into consecutive RAM words while holding the processor in reset.
module data_memory_loader
  import computer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RAM_ADDRESS_WIDTH,
  parameter int COUNT_WIDTH   = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_address,
  input  logic [COUNT_WIDTH-1:0]   word_count,
  input  logic                     abort,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [31:0]              mem_write_data,
  output logic                     mem_write_enable,
  output logic                     processor_hold,
  output logic                     done
);
  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_address;
  logic [COUNT_WIDTH-1:0]   r_remaining;
  logic                     w_push;
  logic                     w_full;
  logic [31:0]              w_word;
  assign w_push = byte_valid && byte_ready;
  byte_word_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .i_clear     (r_state != COLLECT),
    .i_push      (w_push),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_full (w_full)
  );
  // write address/data are separate registers so they hold steady outside WRITE
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state           <= IDLE;
      r_address         <= '0;
      r_remaining       <= '0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      mem_write_enable  <= 1'b0;
      byte_ready        <= 1'b0;
      processor_hold    <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (abort) begin
            r_state        <= DONE;
            byte_ready     <= 1'b0;
            processor_hold <= 1'b0;
            done           <= 1'b1;
          end else if (w_full) begin
            r_state           <= WRITE;
            byte_ready        <= 1'b0;
            mem_write_enable  <= 1'b1;
            mem_write_data    <= w_word;
            mem_write_address <= r_address;
          end
        end
        WRITE: begin
          mem_write_enable <= 1'b0;
          r_address        <= r_address + ADDRESS_WIDTH'(WORD_BYTES);
          r_remaining      <= r_remaining - COUNT_WIDTH'(1);
          if (abort || r_remaining == COUNT_WIDTH'(1)) begin
            r_state        <= DONE;
            processor_hold <= 1'b0;
            done           <= 1'b1;
          end else begin
            r_state    <= COLLECT;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            r_address      <= base_address & ~ADDRESS_WIDTH'(3);
            r_remaining    <= word_count;
            done           <= word_count == '0;
            processor_hold <= word_count != '0;
            byte_ready     <= word_count != '0;
            r_state        <= word_count == '0 ? DONE : COLLECT;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_loader.sv
// tb_data_memory_loader: table-driven load vectors plus directed abort/reset/start corner cases.
module tb_data_memory_loader;
  logic        clock = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [9:0]  base_address = '0;
  logic [8:0]  word_count = '0;
  logic        abort = 0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 0;
  logic        byte_ready;
  logic [9:0]  mem_write_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic        processor_hold;
  logic        done;

  data_memory_loader dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .base_address      (base_address),
    .word_count        (word_count),
    .abort             (abort),
    .byte_data         (byte_data),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_write_enable  (mem_write_enable),
    .processor_hold    (processor_hold),
    .done              (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [9:0]  base;
    logic [8:0]  count;
    bit          gap;
    logic [7:0]  seed;
    logic [7:0]  step;
    int          exp_n;
    logic [9:0]  a0;
    logic [31:0] d0;
    logic [9:0]  al;
    logic [31:0] dl;
  } vec_t;

  vec_t        vt[4];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          we_cyc = 0;
  int          done_cyc = 0;
  bit          done_q = 0;
  bit          hold_seen = 0;
  logic [9:0]  wa[$];
  logic [31:0] wd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    cyc++;
    if (processor_hold) hold_seen = 1;
    if (mem_write_enable) begin
      wa.push_back(mem_write_address);
      wd.push_back(mem_write_data);
      we_cyc = cyc;
      chk("ready_in_write", {31'd0, byte_ready}, 0);
      chk("hold_in_write", {31'd0, processor_hold}, 1);
    end
    if (done && !done_q) done_cyc = cyc;
    done_q = done;
  end

  task automatic feed(input int n, input bit gap, input logic [7:0] seed, input logic [7:0] step);
    int idx = 0;
    int k = 0;
    while (idx < n && k < 400) begin
      @(negedge clock);
      byte_valid = !gap || (k % 2 == 0);
      byte_data  = 8'(seed + 8'(idx) * step);
      if (byte_valid && byte_ready) idx++;
      k++;
    end
    if (idx < n) chk("feed_timeout", idx, n);
    @(negedge clock);
    byte_valid = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("done_reached", {31'd0, done}, 1);
    @(negedge clock);
  endtask

  task automatic begin_load(input logic [9:0] base, input logic [8:0] count);
    wa.delete();
    wd.delete();
    hold_seen = 0;
    @(negedge clock);
    start = 1;
    base_address = base;
    word_count = count;
    @(negedge clock);
    start = 0;
  endtask

  task automatic run_load(input vec_t v);
    begin_load(v.base, v.count);
    chk("start_hold", {31'd0, processor_hold}, {31'd0, v.count != 0});
    chk("start_done", {31'd0, done}, {31'd0, v.count == 0});
    feed(int'(v.count) * 4, v.gap, v.seed, v.step);
    wait_done();
    chk("write_count", wa.size(), v.exp_n);
    chk("hold_after", {31'd0, processor_hold}, 0);
    if (v.exp_n > 0) begin
      chk("first_addr", {22'd0, wa[0]}, {22'd0, v.a0});
      chk("first_data", wd[0], v.d0);
      chk("last_addr", {22'd0, wa[wa.size()-1]}, {22'd0, v.al});
      chk("last_data", wd[wd.size()-1], v.dl);
      chk("done_latency", done_cyc - we_cyc, 1);
    end else begin
      chk("hold_never", {31'd0, hold_seen}, 0);
    end
  endtask

  initial begin
    vt[0] = '{10'h010, 9'd2, 0, 8'h11, 8'h11, 2, 10'h010, 32'h44332211, 10'h014, 32'h88776655};
    vt[1] = '{10'h3FE, 9'd2, 0, 8'h01, 8'h01, 2, 10'h3FC, 32'h04030201, 10'h000, 32'h08070605};
    vt[2] = '{10'h100, 9'd1, 1, 8'hA0, 8'h01, 1, 10'h100, 32'hA3A2A1A0, 10'h100, 32'hA3A2A1A0};
    vt[3] = '{10'h200, 9'd0, 0, 8'h00, 8'h00, 0, 10'h000, 32'h0, 10'h000, 32'h0};
    repeat (2) @(negedge clock);
    reset = 0;
    chk("rst_addr", {22'd0, mem_write_address}, 0);
    chk("rst_data", mem_write_data, 0);
    chk("rst_we", {31'd0, mem_write_enable}, 0);
    chk("rst_ready", {31'd0, byte_ready}, 0);
    chk("rst_hold", {31'd0, processor_hold}, 0);
    chk("rst_done", {31'd0, done}, 0);
    for (int i = 0; i < 4; i++) run_load(vt[i]);
    // abort after six bytes of a three-word load
    begin_load(10'h040, 9'd3);
    feed(6, 0, 8'h01, 8'h01);
    abort = 1;
    @(negedge clock);
    abort = 0;
    wait_done();
    repeat (4) @(negedge clock);
    chk("abort_writes", wa.size(), 1);
    chk("abort_addr", {22'd0, wa[0]}, 32'h040);
    chk("abort_data", wd[0], 32'h04030201);
    chk("abort_hold", {31'd0, processor_hold}, 0);
    // abort coinciding with the write cycle
    begin_load(10'h080, 9'd2);
    feed(4, 0, 8'hC0, 8'h11);
    chk("abortw_in_write", {31'd0, mem_write_enable}, 1);
    abort = 1;
    @(negedge clock);
    abort = 0;
    wait_done();
    chk("abortw_writes", wa.size(), 1);
    chk("abortw_addr", {22'd0, wa[0]}, 32'h080);
    chk("abortw_data", wd[0], 32'hF3E2D1C0);
    // start during COLLECT must not disturb address or count
    begin_load(10'h0C0, 9'd2);
    feed(2, 0, 8'h10, 8'h01);
    start = 1;
    base_address = 10'h300;
    word_count = 9'd5;
    @(negedge clock);
    start = 0;
    feed(6, 0, 8'h12, 8'h01);
    wait_done();
    chk("ign_writes", wa.size(), 2);
    chk("ign_addr0", {22'd0, wa[0]}, 32'h0C0);
    chk("ign_data0", wd[0], 32'h13121110);
    chk("ign_addr1", {22'd0, wa[1]}, 32'h0C4);
    chk("ign_data1", wd[1], 32'h17161514);
    // reset in the middle of COLLECT
    begin_load(10'h1F0, 9'd2);
    feed(2, 0, 8'h90, 8'h01);
    reset = 1;
    @(negedge clock);
    chk("mid_rst_addr", {22'd0, mem_write_address}, 0);
    chk("mid_rst_data", mem_write_data, 0);
    chk("mid_rst_we", {31'd0, mem_write_enable}, 0);
    chk("mid_rst_ready", {31'd0, byte_ready}, 0);
    chk("mid_rst_hold", {31'd0, processor_hold}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    reset = 0;
    run_load(vt[0]);
    run_load(vt[2]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
